// File: rtl/dma_arbiter_if.sv
// Bus bundle for dma_arbiter: Z80 bus handshake, memory-side bus and per-channel DMA client signals.
// The master modport is the arbiter; the slave modport is the CPU/memory/client side.
interface dma_arbiter_if #(
  parameter int NCH = 2,
  parameter int AW  = 21
);
  logic              busrq_n;
  logic              busak_n;
  logic              mem_dma_bus;
  logic [AW-1:0]     mem_dma_addr;
  logic [7:0]        mem_dma_wd;
  logic [7:0]        mem_dma_rd;
  logic              mem_dma_rnw;
  logic              mem_dma_oe;
  logic              mem_dma_we;
  logic [NCH-1:0]    dma_req;
  logic [NCH-1:0]    dma_rnw;
  logic [NCH*AW-1:0] dma_addr;
  logic [NCH*8-1:0]  dma_wd;
  logic [NCH-1:0]    dma_ack;
  logic [NCH-1:0]    dma_end;
  logic [7:0]        dma_rd;

  modport master (
    output busrq_n, input busak_n,
    output mem_dma_bus, mem_dma_addr, mem_dma_wd, input mem_dma_rd,
    output mem_dma_rnw, mem_dma_oe, mem_dma_we,
    input  dma_req, dma_rnw, dma_addr, dma_wd,
    output dma_ack, dma_end, dma_rd
  );

  modport slave (
    input  busrq_n, output busak_n,
    input  mem_dma_bus, mem_dma_addr, mem_dma_wd, output mem_dma_rd,
    input  mem_dma_rnw, mem_dma_oe, mem_dma_we,
    output dma_req, dma_rnw, dma_addr, dma_wd,
    input  dma_ack, dma_end, dma_rd
  );
endinterface

// File: rtl/dma_arbiter.sv
// Round-robin DMA arbiter: takes the Z80 bus via busrq_n/busak_n, serves channel accesses
// back to back, and keeps the bus for HOLD idle clocks before handing it back.
module dma_arbiter #(
  parameter int NCH  = 2,
  parameter int AW   = 21,
  parameter int STRB = 2,
  parameter int HOLD = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  dma_arbiter_if.master bus
);
  localparam int unsigned N  = NCH;
  localparam int          CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {IDLE, WAITAK, ARB, SETUP, STROBE, FIN, HOLDW, REL} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   last_q, last_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      wd_q, wd_d;
  logic [7:0]      rd_q, rd_d;
  logic            acc_rnw_q, acc_rnw_d;
  logic [3:0]      strb_q, strb_d;
  logic [7:0]      idle_q, idle_d;
  logic            busrq_n_q, busrq_n_d;
  logic            own_q, own_d;
  logic            rnw_q, rnw_d;
  logic            oe_q, oe_d;
  logic            we_q, we_d;
  logic [NCH-1:0]  ack_q, ack_d;
  logic [NCH-1:0]  end_q, end_d;

  logic            found;
  logic [CW-1:0]   gnt;
  logic [CW-1:0]   cand;
  logic            abort;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    addr_d    = addr_q;
    wd_d      = wd_q;
    rd_d      = rd_q;
    acc_rnw_d = acc_rnw_q;
    strb_d    = strb_q;
    idle_d    = idle_q;
    ack_d     = '0;
    end_d     = '0;
    found     = 1'b0;
    gnt       = last_q;
    cand      = '0;

    // Search starts just after the last grant so a re-requesting channel goes to the back.
    for (int unsigned i = 1; i <= N; i++) begin
      cand = CW'((32'(last_q) + i) % N);
      if (!found && bus.dma_req[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end

    abort = bus.busak_n && (state_q inside {ARB, SETUP, STROBE, FIN, HOLDW});

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:   if (|bus.dma_req) state_d = WAITAK;
        WAITAK: if (!bus.busak_n) state_d = ARB;
        ARB: begin
          if (found) begin
            state_d     = SETUP;
            ack_d[gnt]  = 1'b1;
            last_d      = gnt;
            addr_d      = bus.dma_addr[32'(gnt)*AW +: AW];
            wd_d        = bus.dma_wd[32'(gnt)*8 +: 8];
            acc_rnw_d   = bus.dma_rnw[gnt];
          end else begin
            state_d = HOLDW;
            idle_d  = '0;
          end
        end
        SETUP: begin
          state_d = STROBE;
          strb_d  = '0;
        end
        STROBE: begin
          if (strb_q == 4'(STRB - 1)) begin
            state_d        = FIN;
            end_d[last_q]  = 1'b1;
            if (acc_rnw_q) rd_d = bus.mem_dma_rd;
          end else begin
            strb_d = strb_q + 4'd1;
          end
        end
        FIN: state_d = ARB;
        HOLDW: begin
          if (|bus.dma_req)                   state_d = ARB;
          else if (idle_q == 8'(HOLD - 1))    state_d = REL;
          else                                idle_d  = idle_q + 8'd1;
        end
        REL:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    busrq_n_d = (state_d == IDLE);
    own_d     = state_d inside {ARB, SETUP, STROBE, FIN, HOLDW};
    rnw_d     = (state_d inside {SETUP, STROBE, FIN}) ? acc_rnw_d : 1'b1;
    oe_d      = !((state_d == STROBE) && acc_rnw_d);
    we_d      = !((state_d == STROBE) && !acc_rnw_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= CW'(NCH - 1);
      addr_q    <= '0;
      wd_q      <= '0;
      rd_q      <= '0;
      acc_rnw_q <= 1'b1;
      strb_q    <= '0;
      idle_q    <= '0;
      busrq_n_q <= 1'b1;
      own_q     <= 1'b0;
      rnw_q     <= 1'b1;
      oe_q      <= 1'b1;
      we_q      <= 1'b1;
      ack_q     <= '0;
      end_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wd_q      <= wd_d;
      rd_q      <= rd_d;
      acc_rnw_q <= acc_rnw_d;
      strb_q    <= strb_d;
      idle_q    <= idle_d;
      busrq_n_q <= busrq_n_d;
      own_q     <= own_d;
      rnw_q     <= rnw_d;
      oe_q      <= oe_d;
      we_q      <= we_d;
      ack_q     <= ack_d;
      end_q     <= end_d;
    end
  end

  assign bus.busrq_n      = busrq_n_q;
  assign bus.mem_dma_bus  = own_q;
  assign bus.mem_dma_addr = addr_q;
  assign bus.mem_dma_wd   = wd_q;
  assign bus.mem_dma_rnw  = rnw_q;
  assign bus.mem_dma_oe   = oe_q;
  assign bus.mem_dma_we   = we_q;
  assign bus.dma_ack      = ack_q;
  assign bus.dma_end      = end_q;
  assign bus.dma_rd       = rd_q;
endmodule
